plp_mnemonic_encoder: RTL
=========================

# plp_mnemonic_encoder

Streaming ASCII-to-instruction encoder for the PLP CPU bench and boot tooling, the inverse of the instruction-to-mnemonic decoding used for trace display. It accepts ASCII characters one per handshake, tokenizes one mnemonic at a time, and emits the 32-bit instruction skeleton for that mnemonic: opcode, func and fixed fields set, register and immediate fields zero. It sits between a byte source (UART receive path or bench driver) and an assembler or loader stage that fills in the operand fields.

## Interface
- No parameters; encodings are the named constants from constant_params.vh (R_TYPE, ADDU, LW, BEQ, ...).
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- char_in  in  8  ASCII character
- char_valid  in  1  char_in is valid
- char_ready  out  1  encoder accepts char_in this cycle
- enc_instr  out  32  instruction skeleton; register/immediate/shamt fields 0
- enc_pseudo  out  1  token was a pseudo-op (nop, move, b)
- enc_err  out  1  token unknown, too long, or contains an illegal character
- enc_valid  out  1  enc_* outputs valid
- enc_ready  in  1  consumer accepts enc_* this cycle

## Operation
- Character accepted when char_valid & char_ready.
- Delimiters: 0x20, 0x09, 0x0A, 0x0D, 0x00. Letters A-Z folded to a-z; a-z stored. Any other character is illegal.
- States: IDLE, ACCUM, DRAIN, LOOKUP, HOLD.
- IDLE: delimiters discarded; letter -> store as char 0, go ACCUM; illegal -> set error latch, go DRAIN.
- ACCUM: letter with count < 5 -> append; letter with count = 5 -> error latch, DRAIN; illegal -> error latch, DRAIN; delimiter -> LOOKUP.
- DRAIN: discard non-delimiters; delimiter -> HOLD with enc_err=1, enc_instr=0, enc_pseudo=0.
- LOOKUP: one cycle, no character accepted. 40-bit buffer, right-padded with 0x20, compared against the table; result registered into enc_*; go HOLD.
- HOLD: enc_valid=1, outputs stable; enc_valid & enc_ready -> IDLE, clear buffer, count, and error latch.
- char_ready = 1 in IDLE/ACCUM/DRAIN, 0 in LOOKUP/HOLD and while rst is high.
- Table, R_TYPE with func: addu, and, jr, jalr, movz, mulhi, mullo, nor, or, sll, sllv, slt, sltu, srl, srlv, subu, xor.
- Table, opcode: addiu, andi, beq, bne, j, jal, lbu, lui, lw, ori, slti, sltiu, sw.
- Layout: opcode [31:26], rs [25:21], rt [20:16], shamt [10:6], func [5:0].
- Pseudo-ops (enc_pseudo=1): nop -> R_TYPE/SLL, shamt 0, i.e. 32'h0000_0000; move -> R_TYPE/ADDU, rt=SPR_Z; b -> BEQ, rs=rt=SPR_Z.
- No table match -> enc_err=1, enc_instr=0.

## Timing
- Reset values: enc_valid=0, enc_err=0, enc_pseudo=0, enc_instr=0, state IDLE, count 0.
- Terminating delimiter accepted in cycle N -> LOOKUP in N+1 -> enc_valid high from N+2.
- DRAIN delimiter accepted in cycle N -> enc_valid high from N+1.
- enc_valid held, with enc_* unchanged, until accepted; no timeout.
- After acceptance in cycle M, char_ready is 1 in M+1.
- rst mid-token or in HOLD: immediate return to reset values; the pending result is lost.
- A single delimiter is consumed as the terminator. Following delimiters are skipped in IDLE.
- A 5-letter token followed by a delimiter is legal ("sltiu").

## Test plan
- Reset release, stream "lw " -> enc_valid 2 cycles after the space; enc_instr[31:26]=LW, other bits 0; err=0, pseudo=0.
- Stream "  NOP\n" with leading spaces -> single result, enc_instr=32'h0000_0000, pseudo=1.
- Stream "sltiu addu " with enc_ready held 0 for 10 cycles on the first result -> char_ready=0 throughout and enc_* stable. Then SLTIU, followed by R_TYPE with func=ADDU.
- Error cases:
  - "mullox " (6 letters) -> err=1, instr=0, and exactly one result.
  - "ad1u " -> err=1.
  - "foo " -> err=1.
  - Next token "b " decodes to BEQ with rs=rt=SPR_Z, pseudo=1.
- Assert rst for 1 cycle after "jal" with no delimiter, then send "or " -> only one result, R_TYPE/OR, and no stale characters in the buffer.
- Sweep all 33 table mnemonics, mixed case, random char_valid gaps -> every enc_instr equals the constant-derived skeleton.

Source files
------------

// File: rtl/plp_mnemonic_encoder.sv
// rtl/plp_mnemonic_encoder.sv - streaming ASCII mnemonic to PLP instruction skeleton encoder
// One mnemonic per token; operand fields of the emitted skeleton are left zero.
module plp_mnemonic_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [31:0] enc_instr,
    output logic        enc_pseudo,
    output logic        enc_err,
    output logic        enc_valid,
    input  logic        enc_ready
);

    localparam logic [5:0] R_TYPE   = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL    = 6'h00;
    localparam logic [5:0] F_SRL    = 6'h02;
    localparam logic [5:0] F_SLLV   = 6'h04;
    localparam logic [5:0] F_SRLV   = 6'h06;
    localparam logic [5:0] F_JR     = 6'h08;
    localparam logic [5:0] F_JALR   = 6'h09;
    localparam logic [5:0] F_MOVZ   = 6'h0A;
    localparam logic [5:0] F_MULLO  = 6'h10;
    localparam logic [5:0] F_MULHI  = 6'h11;
    localparam logic [5:0] F_ADDU   = 6'h21;
    localparam logic [5:0] F_SUBU   = 6'h23;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_XOR    = 6'h26;
    localparam logic [5:0] F_NOR    = 6'h27;
    localparam logic [5:0] F_SLT    = 6'h2A;
    localparam logic [5:0] F_SLTU   = 6'h2B;

    localparam logic [4:0]  SPR_Z     = 5'd0;
    localparam logic [2:0]  MAX_CHARS = 3'd5;
    localparam logic [39:0] BLANK_TOK = {5{8'h20}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_LOOKUP,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [39:0] tok_q, tok_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] instr_q, instr_d;
    logic        pseudo_q, pseudo_d;
    logic        enc_err_q, enc_err_d;

    logic        is_delim;
    logic        is_upper;
    logic        is_lower;
    logic        is_letter;
    logic        is_illegal;
    logic        accept;
    logic [7:0]  char_lc;
    logic [33:0] lut;

    function automatic logic [31:0] r_skel(input logic [5:0] fn);
        return {R_TYPE, 20'd0, fn};
    endfunction

    function automatic logic [31:0] i_skel(input logic [5:0] op);
        return {op, 26'd0};
    endfunction

    // Result is {hit, pseudo, instr}; a miss yields all zeros.
    function automatic logic [33:0] lookup_token(input logic [39:0] tok);
        logic [33:0] r;
        r = 34'd0;
        case (tok)
            "addu ": r = {2'b10, r_skel(F_ADDU)};
            "and  ": r = {2'b10, r_skel(F_AND)};
            "jr   ": r = {2'b10, r_skel(F_JR)};
            "jalr ": r = {2'b10, r_skel(F_JALR)};
            "movz ": r = {2'b10, r_skel(F_MOVZ)};
            "mulhi": r = {2'b10, r_skel(F_MULHI)};
            "mullo": r = {2'b10, r_skel(F_MULLO)};
            "nor  ": r = {2'b10, r_skel(F_NOR)};
            "or   ": r = {2'b10, r_skel(F_OR)};
            "sll  ": r = {2'b10, r_skel(F_SLL)};
            "sllv ": r = {2'b10, r_skel(F_SLLV)};
            "slt  ": r = {2'b10, r_skel(F_SLT)};
            "sltu ": r = {2'b10, r_skel(F_SLTU)};
            "srl  ": r = {2'b10, r_skel(F_SRL)};
            "srlv ": r = {2'b10, r_skel(F_SRLV)};
            "subu ": r = {2'b10, r_skel(F_SUBU)};
            "xor  ": r = {2'b10, r_skel(F_XOR)};
            "addiu": r = {2'b10, i_skel(OP_ADDIU)};
            "andi ": r = {2'b10, i_skel(OP_ANDI)};
            "beq  ": r = {2'b10, i_skel(OP_BEQ)};
            "bne  ": r = {2'b10, i_skel(OP_BNE)};
            "j    ": r = {2'b10, i_skel(OP_J)};
            "jal  ": r = {2'b10, i_skel(OP_JAL)};
            "lbu  ": r = {2'b10, i_skel(OP_LBU)};
            "lui  ": r = {2'b10, i_skel(OP_LUI)};
            "lw   ": r = {2'b10, i_skel(OP_LW)};
            "ori  ": r = {2'b10, i_skel(OP_ORI)};
            "slti ": r = {2'b10, i_skel(OP_SLTI)};
            "sltiu": r = {2'b10, i_skel(OP_SLTIU)};
            "sw   ": r = {2'b10, i_skel(OP_SW)};
            "nop  ": r = {2'b11, r_skel(F_SLL)};
            "move ": r = {2'b11, R_TYPE, 5'd0, SPR_Z, 10'd0, F_ADDU};
            "b    ": r = {2'b11, OP_BEQ, SPR_Z, SPR_Z, 16'd0};
            default: r = 34'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        is_delim   = (char_in == 8'h20) || (char_in == 8'h09) || (char_in == 8'h0A) ||
                     (char_in == 8'h0D) || (char_in == 8'h00);
        is_upper   = (char_in >= 8'h41) && (char_in <= 8'h5A);
        is_lower   = (char_in >= 8'h61) && (char_in <= 8'h7A);
        is_letter  = is_upper || is_lower;
        is_illegal = !is_letter && !is_delim;
        char_lc    = is_upper ? (char_in | 8'h20) : char_in;
        accept     = char_valid && char_ready;
    end

    assign lut = lookup_token(tok_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_letter) begin
                        state_d = S_ACCUM;
                    end else if (is_illegal) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    if (is_delim) begin
                        state_d = S_LOOKUP;
                    end else if (is_illegal || (cnt_q == MAX_CHARS)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && is_delim) begin
                    state_d = S_HOLD;
                end
            end
            S_LOOKUP: state_d = S_HOLD;
            S_HOLD: begin
                if (enc_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        char_ready = 1'b0;
        enc_valid  = 1'b0;
        case (state_q)
            S_IDLE, S_ACCUM, S_DRAIN: char_ready = ~rst;
            S_HOLD:                   enc_valid  = 1'b1;
            default:                  ;
        endcase
    end

    // Token buffer, error latch and the registered result.
    always_comb begin
        tok_d     = tok_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        instr_d   = instr_q;
        pseudo_d  = pseudo_q;
        enc_err_d = enc_err_q;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept) begin
                    if (is_letter && (cnt_q < MAX_CHARS)) begin
                        for (int i = 0; i < 5; i++) begin
                            if (cnt_q == 3'(i)) begin
                                tok_d[8*(4-i) +: 8] = char_lc;
                            end
                        end
                        cnt_d = cnt_q + 3'd1;
                    end else if (!is_delim) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && is_delim) begin
                    instr_d   = 32'd0;
                    pseudo_d  = 1'b0;
                    enc_err_d = err_q;
                end
            end
            S_LOOKUP: begin
                instr_d   = lut[31:0];
                pseudo_d  = lut[32];
                enc_err_d = ~lut[33];
            end
            S_HOLD: begin
                if (enc_ready) begin
                    tok_d = BLANK_TOK;
                    cnt_d = 3'd0;
                    err_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_q     <= BLANK_TOK;
            cnt_q     <= 3'd0;
            err_q     <= 1'b0;
            instr_q   <= 32'd0;
            pseudo_q  <= 1'b0;
            enc_err_q <= 1'b0;
        end else begin
            tok_q     <= tok_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            instr_q   <= instr_d;
            pseudo_q  <= pseudo_d;
            enc_err_q <= enc_err_d;
        end
    end

    assign enc_instr  = instr_q;
    assign enc_pseudo = pseudo_q;
    assign enc_err    = enc_err_q;

endmodule
